cell_test_sequencer: RTL and testbench
======================================

Name: cell_test_sequencer

Overview:
Synchronous controller that runs one test of the cell-under-test harness per command. It drives the harness control pins (mode, trigger, div, source) and samples the harness output (target) after a programmable settle time. The result is returned on a valid/ready response port. The sequencer sits between the host/scan interface and the cell tester; it is the only driver of the tester's control pins.

Parameters:
IN_W, 8, width of tester source vector
OUT_W, 8, width of tester target vector
SETUP_CYC, 2, clk cycles source/div/mode held stable before first trigger edge (>=1)
PULSE_CYC, 2, clk cycles trigger is high (and then low) per manual step (>=1)
SETTLE_CYC, 4, clk cycles after final trigger fall before target sampling (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_mode  in  1  0 = manual step mode, 1 = ring-oscillator burst mode
cmd_div  in  3  ring-oscillator divider select
cmd_vector  in  IN_W  stimulus vector for tester source
cmd_steps  in  8  manual: number of trigger pulses; burst: gate-open length in clk cycles
tst_mode  out  1  to tester mode
tst_trigger  out  1  to tester trigger
tst_div  out  3  to tester div
tst_source  out  IN_W  to tester source
tst_target  in  OUT_W  from tester target (asynchronous to clk)
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed
rsp_data  out  OUT_W  sampled target
rsp_steps  out  8  pulses/gate cycles actually issued
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst high at a clk edge, any state): state IDLE; tst_trigger=0, tst_mode=0, tst_div=0, tst_source=0, rsp_valid=0, rsp_data=0, rsp_steps=0, busy=0, cmd_ready=1 from the cycle after reset. Reset mid-test drops trigger on the same edge. No response is produced for the aborted command.
- Command accept: on the edge where cmd_valid & cmd_ready, latch mode/div/vector/steps. tst_mode, tst_div and tst_source take the latched values on that same edge. They are held constant until the next accept. Go to SETUP.
- FSM states: IDLE, SETUP, PULSE_HI, PULSE_LO, GATE, SETTLE, RESP.
- SETUP: hold for SETUP_CYC cycles with trigger=0.
  - Then: steps==0 -> SETTLE; mode=0 -> PULSE_HI; mode=1 -> GATE.
- PULSE_HI: trigger=1 for PULSE_CYC cycles, then PULSE_LO. The step counter increments on entry to PULSE_HI.
- PULSE_LO: trigger=0 for PULSE_CYC cycles. Then go to PULSE_HI if issued<steps, else SETTLE. Consecutive rising trigger edges are therefore 2*PULSE_CYC apart.
- GATE: trigger=1 for exactly steps cycles, then trigger=0 and go to SETTLE. The counter counts gate cycles.
- SETTLE: trigger=0. tst_target passes through a 2-flop synchronizer that runs continuously. After SETTLE_CYC cycles, load rsp_data from the synchronizer output and rsp_steps from the counter; go to RESP.
- RESP: rsp_valid=1, with rsp_data and rsp_steps stable. Leave on rsp_valid & rsp_ready (same-edge accept): rsp_valid falls, go to IDLE.
  - cmd_ready stays 0 in RESP, so there is no command/response overlap.
- cmd_ready = (state==IDLE). Commands are not accepted during RESP even if rsp_ready is asserted in the same cycle.
- Counter is 8 bits. steps=255 issues 255 pulses/cycles with no wrap. steps=0 issues none, and rsp_steps=0.
- tst_trigger comes directly from a flop (glitch-free): it is a clean edge source for the tester's trigger/gating logic.
- Manual-mode test length (accept to rsp_valid) = SETUP_CYC + 2*PULSE_CYC*steps + SETTLE_CYC + 1 cycles.

Decomposition:
- Shared package cell_test_pkg: state enum (IDLE..RESP), MODE_MANUAL=0 / MODE_BURST=1 constants, default width constants.
- One sub-module, target_sync: a parameterised OUT_W-wide 2-flop synchronizer, reset to 0.
- All timing counters (phase counter sized to max of the *_CYC parameters, 8-bit step counter) stay in the top module.

Test Plan:
- Reset mid-PULSE_HI (mode=0, steps=5, 3rd pulse) -> trigger=0 on next edge, busy=0, cmd_ready=1, no rsp_valid.
- Manual: vector=0xA5, steps=3, defaults, tst_target tied 0x3C:
  - 3 trigger pulses, each 2 high/2 low.
  - tst_source=0xA5 throughout.
  - rsp_valid at accept+19; rsp_data=0x3C, rsp_steps=3.
- Burst: mode=1, div=5, steps=10:
  - tst_mode=1, tst_div=5 from the accept edge.
  - Single trigger-high window of exactly 10 cycles.
  - rsp_steps=10.
- steps=0 in each mode -> trigger never rises; rsp_valid at accept+SETUP_CYC+SETTLE_CYC+1=accept+7; rsp_steps=0.
- Back-pressure: rsp_ready=0 for 20 cycles while cmd_valid=1 -> rsp_valid and data held, cmd_ready=0, no new accept. Then rsp_ready=1 -> IDLE; next command accepted one cycle later.
- steps=255 manual -> exactly 255 rising edges; rsp_steps=0xFF; no counter wrap.

Source files
------------

// File: rtl/cell_test_pkg.sv
// cell_test_pkg: state encoding, mode constants, default sizing and a max helper for the cell test sequencer
package cell_test_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE_HI, PULSE_LO, GATE, SETTLE, RESP} state_e;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_BURST = 1'b1;
  localparam int IN_W_DEF = 8;
  localparam int OUT_W_DEF = 8;
  localparam int SETUP_CYC_DEF = 2;
  localparam int PULSE_CYC_DEF = 2;
  localparam int SETTLE_CYC_DEF = 4;
  function automatic int max3(int a, int b, int c);
    return (a > b ? a : b) > c ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/cell_test_sequencer_if.sv
// cell_test_sequencer_if: cmd/rsp handshakes, tester pins and busy; master = host+tester side, slave = sequencer
interface cell_test_sequencer_if import cell_test_pkg::*; #(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_mode;
  logic [2:0] cmd_div;
  logic [IN_W-1:0] cmd_vector;
  logic [7:0] cmd_steps;
  logic tst_mode;
  logic tst_trigger;
  logic [2:0] tst_div;
  logic [IN_W-1:0] tst_source;
  logic [OUT_W-1:0] tst_target;
  logic rsp_valid;
  logic rsp_ready;
  logic [OUT_W-1:0] rsp_data;
  logic [7:0] rsp_steps;
  logic busy;
  modport master (
    output cmd_valid, cmd_mode, cmd_div, cmd_vector, cmd_steps, tst_target, rsp_ready,
    input cmd_ready, tst_mode, tst_trigger, tst_div, tst_source, rsp_valid, rsp_data, rsp_steps, busy
  );
  modport slave (
    input cmd_valid, cmd_mode, cmd_div, cmd_vector, cmd_steps, tst_target, rsp_ready,
    output cmd_ready, tst_mode, tst_trigger, tst_div, tst_source, rsp_valid, rsp_data, rsp_steps, busy
  );
endinterface

// File: rtl/target_sync.sv
// target_sync: W-wide two-flop synchronizer for the asynchronous tester target bus (clk, rst, d_i -> q_o)
module target_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      q_o <= '0;
    end else begin
      meta_q <= d_i;
      q_o <= meta_q;
    end
  end
endmodule

// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer: runs one cell-tester test per command (clk, rst; bus: cmd in, tester pins out, target in, rsp out, busy)
module cell_test_sequencer import cell_test_pkg::*; #(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input logic clk,
  input logic rst,
  cell_test_sequencer_if.slave bus
);
  localparam int PH_W = $clog2(max3(SETUP_CYC, PULSE_CYC, SETTLE_CYC) + 1);
  state_e st_q, st_d;
  logic [PH_W-1:0] ph_q, ph_d, ph_last;
  logic [7:0] cnt_q, cnt_d, steps_q, rsp_steps_q;
  logic [2:0] div_q;
  logic [IN_W-1:0] vec_q;
  logic [OUT_W-1:0] sync_q, data_q;
  logic mode_q, trig_q, trig_d, accept, ph_end;
  target_sync #(.W(OUT_W)) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(bus.tst_target),
    .q_o(sync_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      ph_q <= '0;
      cnt_q <= '0;
      trig_q <= 1'b0;
      mode_q <= 1'b0;
      div_q <= '0;
      vec_q <= '0;
      steps_q <= '0;
      data_q <= '0;
      rsp_steps_q <= '0;
    end else begin
      st_q <= st_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      trig_q <= trig_d;
      if (accept) begin
        mode_q <= bus.cmd_mode;
        div_q <= bus.cmd_div;
        vec_q <= bus.cmd_vector;
        steps_q <= bus.cmd_steps;
      end
      if (st_q == SETTLE && ph_end) begin
        data_q <= sync_q;
        rsp_steps_q <= cnt_q;
      end
    end
  end
  always_comb begin
    accept = bus.cmd_valid && st_q == IDLE;
    ph_last = st_q == SETUP ? PH_W'(SETUP_CYC - 1) : st_q == SETTLE ? PH_W'(SETTLE_CYC - 1) : PH_W'(PULSE_CYC - 1);
    ph_end = ph_q == ph_last;
    st_d = st_q;
    case (st_q)
      IDLE:     st_d = bus.cmd_valid ? SETUP : IDLE;
      SETUP:    st_d = !ph_end ? SETUP : steps_q == 8'd0 ? SETTLE : mode_q == MODE_MANUAL ? PULSE_HI : GATE;
      PULSE_HI: st_d = ph_end ? PULSE_LO : PULSE_HI;
      PULSE_LO: st_d = !ph_end ? PULSE_LO : cnt_q < steps_q ? PULSE_HI : SETTLE;
      GATE:     st_d = cnt_q == steps_q ? SETTLE : GATE;
      SETTLE:   st_d = ph_end ? RESP : SETTLE;
      RESP:     st_d = bus.rsp_ready ? IDLE : RESP;
      default:  st_d = IDLE;
    endcase
    ph_d = st_d != st_q ? '0 : ph_q + PH_W'(1);
    cnt_d = accept ? 8'd0 : (st_d == GATE || (st_d == PULSE_HI && st_q != PULSE_HI)) ? cnt_q + 8'd1 : cnt_q;
    trig_d = st_d == PULSE_HI || st_d == GATE;
  end
  always_comb begin
    bus.cmd_ready = st_q == IDLE;
    bus.busy = st_q != IDLE;
    bus.rsp_valid = st_q == RESP;
    bus.rsp_data = data_q;
    bus.rsp_steps = rsp_steps_q;
    bus.tst_trigger = trig_q;
    bus.tst_mode = mode_q;
    bus.tst_div = div_q;
    bus.tst_source = vec_q;
  end
endmodule

// File: tb/tb_cell_test_sequencer.sv
// tb_cell_test_sequencer: randomized self-checking bench against a cycle-count model of the cell test sequencer
module tb_cell_test_sequencer;
  import cell_test_pkg::*;
  localparam int IN_W = 8;
  localparam int OUT_W = 8;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 2;
  localparam int SETTLE_CYC = 4;
  typedef struct packed {
    int lat;
    int rises;
    int hi;
    int maxrun;
    int minrun;
    int hold;
    logic [OUT_W-1:0] data;
    logic [7:0] steps;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  cell_test_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  cell_test_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic obs_t model(logic m, int s, logic [OUT_W-1:0] t);
    obs_t e;
    e = '0;
    e.lat = SETUP_CYC + (m ? s : 2 * PULSE_CYC * s) + SETTLE_CYC + 1;
    e.rises = s == 0 ? 0 : (m ? 1 : s);
    e.hi = m ? s : PULSE_CYC * s;
    e.maxrun = s == 0 ? 0 : (m ? s : PULSE_CYC);
    e.minrun = s == 0 ? 1000 : e.maxrun;
    e.data = t;
    e.steps = 8'(s);
    return e;
  endfunction
  task automatic run_cmd(input logic m, input logic [2:0] d, input logic [IN_W-1:0] v, input logic [7:0] s,
                         input logic [OUT_W-1:0] t, output obs_t o);
    int run;
    logic prev;
    o = '0;
    o.minrun = 1000;
    run = 0;
    prev = 1'b0;
    bus.tst_target = t;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode = m;
    bus.cmd_div = d;
    bus.cmd_vector = v;
    bus.cmd_steps = s;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode = 1'($urandom);
    bus.cmd_div = 3'($urandom);
    bus.cmd_vector = IN_W'($urandom);
    bus.cmd_steps = 8'($urandom);
    o.lat = 1;
    while (!bus.rsp_valid && o.lat < 3000) begin
      if (bus.tst_mode !== m || bus.tst_div !== d || bus.tst_source !== v || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) o.hold++;
      if (bus.tst_trigger) begin
        o.hi++;
        run++;
        if (!prev) o.rises++;
      end else if (prev) begin
        o.maxrun = run > o.maxrun ? run : o.maxrun;
        o.minrun = run < o.minrun ? run : o.minrun;
        run = 0;
      end
      prev = bus.tst_trigger;
      @(posedge clk); #1;
      o.lat++;
    end
    o.data = bus.rsp_data;
    o.steps = bus.rsp_steps;
  endtask
  task automatic ack(input int hold_cycles, output int bad);
    logic [OUT_W-1:0] d0;
    logic [7:0] s0;
    d0 = bus.rsp_data;
    s0 = bus.rsp_steps;
    bad = 0;
    bus.tst_target = OUT_W'($urandom);
    repeat (hold_cycles) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_mode = 1'($urandom);
      bus.cmd_div = 3'($urandom);
      bus.cmd_vector = IN_W'($urandom);
      bus.cmd_steps = 8'($urandom_range(1, 9));
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.rsp_steps !== s0 || bus.cmd_ready !== 1'b0 ||
          bus.busy !== 1'b1 || bus.tst_trigger !== 1'b0) bad++;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) bad++;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.tst_trigger, bus.tst_mode, bus.tst_div, bus.tst_source} !== '0) begin
      errors++;
      $display("FAIL reset_tst got %b/%b/%h/%h want 0", bus.tst_trigger, bus.tst_mode, bus.tst_div, bus.tst_source);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_steps} !== '0) begin
      errors++;
      $display("FAIL reset_rsp got %b/%h/%h want 0", bus.rsp_valid, bus.rsp_data, bus.rsp_steps);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs busy=%b ready=%b want 0/1", bus.busy, bus.cmd_ready);
    end
  endtask
  task automatic test_manual;
    obs_t o, e;
    int bad, s;
    logic [IN_W-1:0] v;
    logic [OUT_W-1:0] t;
    run_cmd(MODE_MANUAL, 3'd0, 8'hA5, 8'd3, 8'h3C, o);
    e = model(MODE_MANUAL, 3, 8'h3C);
    checks++;
    if (o !== e) begin errors++; $display("FAIL manual_a5 got %p want %p", o, e); end
    ack(0, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL manual_a5_ack bad=%0d want 0", bad); end
    repeat (4) begin
      s = $urandom_range(1, 20);
      v = IN_W'($urandom);
      t = OUT_W'($urandom);
      run_cmd(MODE_MANUAL, 3'($urandom), v, 8'(s), t, o);
      e = model(MODE_MANUAL, s, t);
      checks++;
      if (o !== e) begin errors++; $display("FAIL manual_rand s=%0d got %p want %p", s, o, e); end
      ack($urandom_range(0, 3), bad);
      bus.cmd_valid = 1'b0;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL manual_rand_ack bad=%0d want 0", bad); end
    end
  endtask
  task automatic test_burst;
    obs_t o, e;
    int bad, s;
    logic [OUT_W-1:0] t;
    t = OUT_W'($urandom);
    run_cmd(MODE_BURST, 3'd5, IN_W'($urandom), 8'd10, t, o);
    e = model(MODE_BURST, 10, t);
    checks++;
    if (o !== e) begin errors++; $display("FAIL burst_10 got %p want %p", o, e); end
    ack(0, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL burst_10_ack bad=%0d want 0", bad); end
    repeat (3) begin
      s = $urandom_range(1, 60);
      t = OUT_W'($urandom);
      run_cmd(MODE_BURST, 3'($urandom), IN_W'($urandom), 8'(s), t, o);
      e = model(MODE_BURST, s, t);
      checks++;
      if (o !== e) begin errors++; $display("FAIL burst_rand s=%0d got %p want %p", s, o, e); end
      ack(0, bad);
    end
  endtask
  task automatic test_zero_steps;
    obs_t o, e;
    int bad;
    logic [OUT_W-1:0] t;
    for (int m = 0; m < 2; m++) begin
      t = OUT_W'($urandom);
      run_cmd(1'(m), 3'($urandom), IN_W'($urandom), 8'd0, t, o);
      e = model(1'(m), 0, t);
      checks++;
      if (o !== e) begin errors++; $display("FAIL zero_steps mode=%0d got %p want %p", m, o, e); end
      ack(0, bad);
    end
  endtask
  task automatic test_back_pressure;
    obs_t o, e;
    int bad, n;
    logic [IN_W-1:0] v2;
    logic [OUT_W-1:0] t;
    t = OUT_W'($urandom);
    run_cmd(MODE_MANUAL, 3'd2, IN_W'($urandom), 8'd2, t, o);
    e = model(MODE_MANUAL, 2, t);
    checks++;
    if (o !== e) begin errors++; $display("FAIL bp_cmd got %p want %p", o, e); end
    ack(20, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold bad=%0d want 0", bad); end
    v2 = IN_W'($urandom);
    bus.cmd_mode = MODE_MANUAL;
    bus.cmd_div = 3'd7;
    bus.cmd_vector = v2;
    bus.cmd_steps = 8'd1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.tst_source !== v2 || bus.tst_div !== 3'd7) begin
      errors++;
      $display("FAIL bp_next_accept busy=%b src=%h div=%0d want 1/%h/7", bus.busy, bus.tst_source, bus.tst_div, v2);
    end
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_steps !== 8'd1) begin
      errors++;
      $display("FAIL bp_next_rsp valid=%b steps=%0d want 1/1", bus.rsp_valid, bus.rsp_steps);
    end
    ack(0, bad);
  endtask
  task automatic test_back_to_back;
    obs_t o, e;
    int bad, s;
    logic m;
    logic [OUT_W-1:0] t;
    repeat (6) begin
      m = 1'($urandom);
      s = $urandom_range(0, 15);
      t = OUT_W'($urandom);
      run_cmd(m, 3'($urandom), IN_W'($urandom), 8'(s), t, o);
      e = model(m, s, t);
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b m=%0d s=%0d got %p want %p", m, s, o, e); end
      ack(0, bad);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL b2b_ack bad=%0d want 0", bad); end
    end
  endtask
  task automatic test_max_steps;
    obs_t o, e;
    int bad;
    logic [OUT_W-1:0] t;
    t = OUT_W'($urandom);
    run_cmd(MODE_MANUAL, 3'd1, IN_W'($urandom), 8'd255, t, o);
    e = model(MODE_MANUAL, 255, t);
    checks++;
    if (o !== e) begin errors++; $display("FAIL max_steps got %p want %p", o, e); end
    ack(0, bad);
  endtask
  task automatic test_reset_mid;
    int r, n, late;
    logic prev;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode = MODE_MANUAL;
    bus.cmd_div = 3'd3;
    bus.cmd_vector = IN_W'($urandom_range(1, 255));
    bus.cmd_steps = 8'd5;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    r = 0;
    n = 0;
    prev = 1'b0;
    while (r < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.tst_trigger && !prev) r++;
      prev = bus.tst_trigger;
    end
    checks++;
    if (r !== 3) begin errors++; $display("FAIL reset_mid_reach pulses=%0d want 3", r); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.tst_trigger !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.tst_source !== '0) begin
      errors++;
      $display("FAIL reset_mid trig=%b busy=%b ready=%b rsp=%b src=%h want 0/0/1/0/0",
               bus.tst_trigger, bus.busy, bus.cmd_ready, bus.rsp_valid, bus.tst_source);
    end
    late = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || bus.tst_trigger !== 1'b0 || bus.busy !== 1'b0) late++;
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL reset_mid_quiet bad_cycles=%0d want 0", late); end
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mode = 1'b0;
    bus.cmd_div = '0;
    bus.cmd_vector = '0;
    bus.cmd_steps = '0;
    bus.rsp_ready = 1'b0;
    bus.tst_target = '0;
    test_reset;
    test_manual;
    test_burst;
    test_zero_steps;
    test_back_pressure;
    test_back_to_back;
    test_max_steps;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
